// File: rtl/spi_master_driver.sv
// rtl/spi_master_driver.sv - SPI master frame driver: 10-bit command/payload out, optional 8-bit read-back
// One bit per clk; all pin-level outputs come straight from flops.
module spi_master_driver #(
  parameter int RD_WAIT = 2
) (
  input  logic       clk,
  input  logic       a_rst_n,
  input  logic       start,
  input  logic [1:0] cmd,
  input  logic [7:0] wdata,
  input  logic       MISO,
  output logic       SS_n,
  output logic       MOSI,
  output logic       busy,
  output logic       done,
  output logic [7:0] rd_data,
  output logic       rd_valid
);

  localparam logic [2:0] IDLE      = 3'd0;
  localparam logic [2:0] SELECT    = 3'd1;
  localparam logic [2:0] SHIFT_OUT = 3'd2;
  localparam logic [2:0] WAIT_RD   = 3'd3;
  localparam logic [2:0] SHIFT_IN  = 3'd4;
  localparam logic [2:0] END       = 3'd5;

  localparam logic [3:0] WAIT_LAST = 4'(RD_WAIT - 1);

  logic [2:0] state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic [9:0] tx_q, tx_d;
  logic [7:0] rx_q, rx_d;
  logic       rd_q, rd_d;
  logic       ss_n_q, ss_n_d;
  logic       mosi_q, mosi_d;
  logic       done_q, done_d;
  logic       rd_valid_q, rd_valid_d;
  logic [7:0] rd_data_q, rd_data_d;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    tx_d       = tx_q;
    rx_d       = rx_q;
    rd_d       = rd_q;
    rd_data_d  = rd_data_q;
    mosi_d     = 1'b0;
    done_d     = 1'b0;
    rd_valid_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          tx_d    = {cmd, wdata};
          rd_d    = (cmd == 2'b11);
          cnt_d   = 4'd0;
          mosi_d  = cmd[1];
          state_d = SELECT;
        end
      end
      SELECT: begin
        cnt_d   = 4'd0;
        mosi_d  = tx_q[9];
        state_d = SHIFT_OUT;
      end
      SHIFT_OUT: begin
        if (cnt_q == 4'd9) begin
          cnt_d   = 4'd0;
          state_d = rd_q ? WAIT_RD : END;
          done_d  = !rd_q;
        end else begin
          // Shift first so the next MSB is always at bit 8 when presented.
          cnt_d  = cnt_q + 4'd1;
          tx_d   = {tx_q[8:0], 1'b0};
          mosi_d = tx_q[8];
        end
      end
      WAIT_RD: begin
        if (cnt_q == WAIT_LAST) begin
          cnt_d   = 4'd0;
          state_d = SHIFT_IN;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      SHIFT_IN: begin
        rx_d = {rx_q[6:0], MISO};
        if (cnt_q == 4'd7) begin
          cnt_d      = 4'd0;
          state_d    = END;
          done_d     = 1'b1;
          rd_valid_d = 1'b1;
          rd_data_d  = {rx_q[6:0], MISO};
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      END: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    ss_n_d = (state_d == IDLE) || (state_d == END);
  end

  always_ff @(posedge clk) begin
    if (!a_rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= 4'd0;
      tx_q       <= 10'd0;
      rx_q       <= 8'd0;
      rd_q       <= 1'b0;
      ss_n_q     <= 1'b1;
      mosi_q     <= 1'b0;
      done_q     <= 1'b0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= 8'h00;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      tx_q       <= tx_d;
      rx_q       <= rx_d;
      rd_q       <= rd_d;
      ss_n_q     <= ss_n_d;
      mosi_q     <= mosi_d;
      done_q     <= done_d;
      rd_valid_q <= rd_valid_d;
      rd_data_q  <= rd_data_d;
    end
  end

  assign SS_n     = ss_n_q;
  assign MOSI     = mosi_q;
  assign busy     = (state_q != IDLE);
  assign done     = done_q;
  assign rd_valid = rd_valid_q;
  assign rd_data  = rd_data_q;

endmodule

// File: tb/tb_spi_master_driver.sv
// tb/tb_spi_master_driver.sv - directed bench for spi_master_driver with a small SPI slave/RAM model
module tb_spi_master_driver;

  localparam int RD_WAIT = 2;

  logic       clk = 1'b0;
  logic       a_rst_n;
  logic       start;
  logic [1:0] cmd;
  logic [7:0] wdata;
  logic       MISO;
  logic       SS_n;
  logic       MOSI;
  logic       busy;
  logic       done;
  logic [7:0] rd_data;
  logic       rd_valid;

  spi_master_driver #(.RD_WAIT(RD_WAIT)) dut (
    .clk      (clk),
    .a_rst_n  (a_rst_n),
    .start    (start),
    .cmd      (cmd),
    .wdata    (wdata),
    .MISO     (MISO),
    .SS_n     (SS_n),
    .MOSI     (MOSI),
    .busy     (busy),
    .done     (done),
    .rd_data  (rd_data),
    .rd_valid (rd_valid)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] slv_mem [256];
  logic [7:0] slv_addr;

  int          f_ss_low, f_done_cyc, f_done_cnt, f_rv_cnt, f_busy_bad;
  logic        f_rv_at_done, f_ss_end, f_ss_idle, f_busy_idle;
  logic [10:0] f_mosi;
  logic [7:0]  f_rd_at_done, f_rd_first;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Starts a frame in the current (IDLE) cycle, plays the slave, stops one cycle after done.
  task automatic run_frame(input logic [1:0] c, input logic [7:0] w, input int pulse_a, input int pulse_b);
    logic [9:0] word;
    logic [7:0] rbyte;
    bit         seen_done;
    f_ss_low = 0; f_done_cyc = -1; f_done_cnt = 0; f_rv_cnt = 0; f_busy_bad = 0;
    f_rv_at_done = 1'b0; f_ss_end = 1'b0; f_mosi = 11'd0; f_rd_at_done = 8'h00; f_rd_first = 8'h00;
    rbyte = 8'h00;
    seen_done = 1'b0;
    cmd = c; wdata = w; start = 1'b1;
    for (int k = 1; k <= 40 && !seen_done; k++) begin
      tick();
      start = (k == pulse_a) || (k == pulse_b);
      cmd   = ~c;
      wdata = ~w;
      if (k == 1) f_rd_first = rd_data;
      if (SS_n === 1'b0) f_ss_low++;
      if (busy !== 1'b1) f_busy_bad++;
      if (k <= 11) f_mosi = {f_mosi[9:0], MOSI};
      if (k == 11) begin
        word = f_mosi[9:0];
        case (word[9:8])
          2'b00:   slv_addr = word[7:0];
          2'b01:   slv_mem[slv_addr] = word[7:0];
          2'b10:   slv_addr = word[7:0];
          default: rbyte = slv_mem[slv_addr];
        endcase
      end
      if (k >= 12 + RD_WAIT && k < 12 + RD_WAIT + 8) MISO = rbyte[7 - (k - 12 - RD_WAIT)];
      else MISO = 1'($urandom_range(0, 1));
      if (rd_valid === 1'b1) f_rv_cnt++;
      if (done === 1'b1) begin
        f_done_cnt++;
        f_done_cyc   = k;
        seen_done    = 1'b1;
        f_rv_at_done = rd_valid;
        f_rd_at_done = rd_data;
        f_ss_end     = SS_n;
      end
    end
    start = 1'b0;
    tick();
    f_ss_idle   = SS_n;
    f_busy_idle = busy;
  endtask

  initial begin
    int extra_low, extra_done;
    for (int i = 0; i < 256; i++) slv_mem[i] = 8'h00;
    slv_addr = 8'h00;
    a_rst_n = 1'b0; start = 1'b1; cmd = 2'b11; wdata = 8'hFF; MISO = 1'b1;

    // Reset with start held high: start must be discarded
    tick(); tick(); tick();
    a_rst_n = 1'b1; start = 1'b0;
    chk("rst_ss_n", SS_n, 1);
    chk("rst_mosi", MOSI, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_rd_valid", rd_valid, 0);
    chk("rst_rd_data", rd_data, 8'h00);
    tick();
    chk("rst_start_discarded", busy, 0);

    // Write address A5
    run_frame(2'b00, 8'hA5, 0, 0);
    chk("wa_mosi_seq", f_mosi, 11'b0_00_10100101);
    chk("wa_ss_low", f_ss_low, 11);
    chk("wa_done_cyc", f_done_cyc, 12);
    chk("wa_done_cnt", f_done_cnt, 1);
    chk("wa_rv_cnt", f_rv_cnt, 0);
    chk("wa_busy", f_busy_bad, 0);
    chk("wa_ss_end", f_ss_end, 1);
    chk("wa_ss_idle", f_ss_idle, 1);
    chk("wa_busy_idle", f_busy_idle, 0);

    // Read data 3C
    slv_addr = 8'h20; slv_mem[8'h20] = 8'h3C;
    run_frame(2'b11, 8'h5A, 0, 0);
    chk("rd_mosi_first3", f_mosi[10:8], 3'b111);
    chk("rd_ss_low", f_ss_low, 21);
    chk("rd_done_cyc", f_done_cyc, 22);
    chk("rd_rv_at_done", f_rv_at_done, 1);
    chk("rd_rv_cnt", f_rv_cnt, 1);
    chk("rd_data_at_done", f_rd_at_done, 8'h3C);
    chk("rd_data_held", rd_data, 8'h3C);

    // Write data with start pulses mid-frame
    run_frame(2'b01, 8'hC4, 3, 7);
    chk("wd_done_cyc", f_done_cyc, 12);
    chk("wd_done_cnt", f_done_cnt, 1);
    chk("wd_mosi_seq", f_mosi, 11'b0_01_11000100);
    extra_low = 0; extra_done = 0;
    for (int k = 0; k < 20; k++) begin
      if (SS_n === 1'b0) extra_low++;
      if (done === 1'b1) extra_done++;
      tick();
    end
    chk("wd_no_extra_frame", extra_low, 0);
    chk("wd_no_extra_done", extra_done, 0);
    chk("wd_rd_data_kept", rd_data, 8'h3C);

    // Back-to-back read address then read data
    slv_mem[8'h0F] = 8'hC3;
    run_frame(2'b10, 8'h0F, 0, 0);
    chk("b2b_ra_rd_kept", rd_data, 8'h3C);
    chk("b2b_ss_end", f_ss_end, 1);
    chk("b2b_ss_idle", f_ss_idle, 1);
    run_frame(2'b11, 8'h00, 0, 0);
    chk("b2b_ss_low", f_ss_low, 21);
    chk("b2b_rd_first", f_rd_first, 8'h3C);
    chk("b2b_done_cyc", f_done_cyc, 22);
    chk("b2b_rd_at_done", f_rd_at_done, 8'hC3);

    // Reset at SHIFT_IN bit 4 of a read-data frame
    cmd = 2'b11; wdata = 8'h00; start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 1; k < 18; k++) tick();
    chk("abort_pre_ss", SS_n, 0);
    a_rst_n = 1'b0; start = 1'b1;
    tick();
    a_rst_n = 1'b1; start = 1'b0;
    chk("abort_ss_n", SS_n, 1);
    chk("abort_rd_data", rd_data, 8'h00);
    chk("abort_done", done, 0);
    chk("abort_rd_valid", rd_valid, 0);
    chk("abort_busy", busy, 0);
    tick();
    chk("abort_start_discarded", busy, 0);
    chk("abort_ss_stays", SS_n, 1);

    // Slave RAM round trip
    slv_mem[8'h10] = 8'h00;
    run_frame(2'b00, 8'h10, 0, 0);
    run_frame(2'b01, 8'h77, 0, 0);
    chk("ram_slave_written", slv_mem[8'h10], 8'h77);
    run_frame(2'b10, 8'h10, 0, 0);
    run_frame(2'b11, 8'hEE, 0, 0);
    chk("ram_rd_valid", f_rv_at_done, 1);
    chk("ram_rd_data", f_rd_at_done, 8'h77);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
